// File: rtl/shift_reg_pkg.sv
// Shared types and defaults for the PISO framer slice.
// PISO_PARITY_EN adds the PAR state (even parity bit after the data bits).
package shift_reg_pkg;

    localparam int unsigned PISO_WIDTH_DEF = 4;

`ifdef PISO_PARITY_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } piso_state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } piso_state_e;
`endif

endpackage

// File: rtl/piso_shifter.sv
// Loadable right-shifting register; lsb is the next data bit to transmit.
module piso_shifter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Load wins over shift; zeros enter from the top.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign lsb = shreg_q[0];

endmodule

// File: rtl/piso_framer.sv
// Parallel-in serial-out framer: start bit, WIDTH data bits LSB first, stop bit.
// Define PISO_PARITY_EN to insert an even parity bit before the stop bit.
module piso_framer
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH    = PISO_WIDTH_DEF,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;

    logic sout_q,      sout_d;
    logic busy_q,      busy_d;
    logic done_q,      done_d;
    logic din_ready_q, din_ready_d;

    logic accept;
    logic shift;
    logic shr_lsb;

`ifdef PISO_PARITY_EN
    logic parity_q;
    logic parity_d;
`endif

    // din_ready_q is a pure decode of state, so acceptance has no path from din_valid to din_ready.
    assign accept = din_valid && din_ready_q;

    piso_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .din   (din),
        .lsb   (shr_lsb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bit counter.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = DATA;
            end
            DATA: begin
                if (bit_cnt_q == CNT_LAST) begin
`ifdef PISO_PARITY_EN
                    state_d = PAR;
`else
                    state_d = STOP;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                state_d = PAR == state_q ? STOP : state_q;
            end
`endif
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so sout tracks the state it belongs to.
    always_comb begin
        sout_d      = IDLE_LVL;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        din_ready_d = 1'b0;
        shift       = 1'b0;
        case (state_d)
            IDLE: begin
                busy_d      = 1'b0;
                din_ready_d = 1'b1;
                done_d      = (state_q == STOP);
            end
            START: begin
                sout_d = ~IDLE_LVL;
            end
            DATA: begin
                sout_d = shr_lsb;
                shift  = 1'b1;
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                sout_d = parity_q;
            end
`endif
            STOP: begin
                sout_d = IDLE_LVL;
            end
            default: begin
                busy_d      = 1'b0;
                din_ready_d = 1'b1;
            end
        endcase
    end

`ifdef PISO_PARITY_EN
    // Parity is fixed at acceptance so later din changes cannot disturb it.
    always_comb begin
        parity_d = parity_q;
        if (accept) begin
            parity_d = ^din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q   <= '0;
            sout_q      <= IDLE_LVL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            din_ready_q <= 1'b1;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            sout_q      <= sout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            din_ready_q <= din_ready_d;
        end
    end

    assign sout      = sout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign din_ready = din_ready_q;

endmodule

// File: tb/tb_piso_framer.sv
// Self-checking bench for piso_framer (WIDTH=4, IDLE_LVL=0) against a bit-queue frame model.
module tb_piso_framer;

    localparam int unsigned W  = 4;
    localparam logic        IL = 1'b0;
`ifdef PISO_PARITY_EN
    localparam int unsigned FL        = W + 3;
    localparam logic [31:0] FRAME_EXP = 32'b0110111;
`else
    localparam int unsigned FL        = W + 2;
    localparam logic [31:0] FRAME_EXP = 32'b010111;
`endif

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         din_valid = 1'b0;
    logic [W-1:0] din       = '0;
    logic         din_ready;
    logic         sout;
    logic         busy;
    logic         done;

    int    n_checks       = 0;
    int    n_fail         = 0;
    int    dut_done_cnt   = 0;
    int    model_done_cnt = 0;
    string phase          = "init";

    // Reference model: the remaining bits of the frame in flight.
    logic exp_q[$];
    logic exp_sout = IL;
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;

    piso_framer #(
        .WIDTH    (W),
        .IDLE_LVL (IL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_sout = IL;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endtask

    // One rising edge of the model: accept if idle, then emit the next frame bit.
    task automatic model_edge(output logic accepted);
        logic prev_busy;
        accepted = 1'b0;
        if (!rst) begin
            model_reset();
        end else begin
            if (!exp_busy && din_valid) begin
                accepted = 1'b1;
                exp_q.push_back(~IL);
                for (int i = 0; i < W; i++) exp_q.push_back(din[i]);
`ifdef PISO_PARITY_EN
                exp_q.push_back(^din);
`endif
                exp_q.push_back(IL);
            end
            prev_busy = exp_busy;
            if (exp_q.size() > 0) begin
                exp_sout = exp_q.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_sout = IL;
                exp_busy = 1'b0;
            end
            exp_done = prev_busy && !exp_busy;
            if (exp_done) model_done_cnt++;
        end
    endtask

    task automatic check_outputs();
        chk("sout", 32'(sout), 32'(exp_sout));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("din_ready", 32'(din_ready), 32'(!exp_busy));
        if (done === 1'b1) dut_done_cnt++;
    endtask

    // Advance one clock; dut_hs is the handshake the DUT offered at that edge.
    task automatic step(output logic dut_hs);
        logic macc;
        dut_hs = din_valid && din_ready && rst;
        @(posedge clk);
        model_edge(macc);
        #1;
        chk("handshake", 32'(dut_hs), 32'(macc));
        check_outputs();
    endtask

    initial begin
        logic        hs;
        logic [31:0] got;
        int          words;
        int          guard;

        // Reset held with din_valid high: nothing may be accepted.
        phase = "reset";
        #2 rst = 1'b0;
        din_valid = 1'b1;
        din       = 4'hB;
        #1;
        model_reset();
        check_outputs();
        repeat (2) step(hs);

        // Release between edges; the first edge with rst=1 accepts 4'b1011.
        #3 rst = 1'b1;
        phase = "single";
        got = '0;
        step(hs);
        got[0] = sout;
        din_valid = 1'b0;
        din       = 4'h0;
        for (int k = 1; k < FL; k++) begin
            step(hs);
            got[k] = sout;
        end
        chk("frame_bits", got, FRAME_EXP);
        step(hs);
        chk("done_pulse", 32'(done), 32'(1));
        step(hs);
        chk("done_single", 32'(done), 32'(0));
        repeat (2) step(hs);

        // Back-to-back: valid held, words A then 5.
        phase = "b2b";
        din_valid = 1'b1;
        din       = 4'hA;
        words = 0;
        guard = 0;
        while (words < 2 && guard < 40) begin
            step(hs);
            guard++;
            if (hs) begin
                words++;
                if (words == 1) din = 4'h5;
                else din_valid = 1'b0;
            end
        end
        chk("b2b_in_time", 32'(guard < 40), 32'(1));
        repeat (FL + 3) step(hs);

        // Busy rejection: 4'hF offered mid-DATA must be ignored.
        phase = "busy_rej";
        din_valid = 1'b1;
        din       = 4'h6;
        step(hs);
        din_valid = 1'b0;
        repeat (3) step(hs);
        din_valid = 1'b1;
        din       = 4'hF;
        step(hs);
        chk("busy_no_accept", 32'(hs), 32'(0));
        din_valid = 1'b0;
        repeat (FL + 3) step(hs);

        // Mid-frame reset during data bit 2, then a clean frame.
        phase = "mid_rst";
        din_valid = 1'b1;
        din       = 4'h9;
        step(hs);
        din_valid = 1'b0;
        repeat (3) step(hs);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) step(hs);
        #3 rst = 1'b1;
        din_valid = 1'b1;
        din       = 4'hC;
        step(hs);
        din_valid = 1'b0;
        repeat (FL + 3) step(hs);

        // Random traffic with a well-behaved upstream that holds din until accepted.
        phase = "random";
        hs = 1'b0;
        repeat (300) begin
            if (!din_valid || hs) begin
                din_valid = 1'($urandom_range(0, 1));
                din       = W'($urandom);
            end
            step(hs);
        end
        din_valid = 1'b0;
        repeat (FL + 3) step(hs);

        phase = "final";
        chk("done_total", 32'(dut_done_cnt), 32'(model_done_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
